// File: rtl/if_id_fetch_stage_pkg.sv
// Pipeline-wide shared definitions.
//   fetch_state_e : IF-stage fetch FSM states
//   NOP_INSTR     : instruction used for bubbles/flushes (mov r0,r0)
//   PC_INC        : sequential PC step
//   if_id_t       : {instr, pc_plus4, valid} pipeline register bundle
package if_id_fetch_stage_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_fetch_stage_pc_register.sv
// Program counter register.
//   clk, reset  : clock, synchronous active-high reset (loads RESET_PC)
//   load        : load load_target (word-aligned by the caller)
//   inc         : advance by PC_INC (modulo 2^32)
//   pc          : current PC
// Priority: reset > load > inc > hold.
module if_id_fetch_stage_pc_register
    import if_id_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_target,
    input  logic        inc,
    output logic [31:0] pc
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_target;
        end else if (inc) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
//   clk, reset                        : clock, synchronous active-high reset
//   IF_imem_req, IF_pc                : level fetch request / word address
//   IF_imem_ready, IF_imem_data       : word at IF_pc is valid this cycle
//   ID_stall                          : hold PC and IF/ID register
//   ID_branch_taken, ID_branch_target : redirect request from ID
//   ID_instr, ID_pc_plus4, ID_valid   : IF/ID register contents
// A one-entry skid buffer catches the word returned while ID is stalled.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = if_id_fetch_stage_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    output logic        IF_imem_req,
    output logic [31:0] IF_pc,
    input  logic        IF_imem_ready,
    input  logic [31:0] IF_imem_data,
    input  logic        ID_stall,
    input  logic        ID_branch_taken,
    input  logic [31:0] ID_branch_target,
    output logic [31:0] ID_instr,
    output logic [31:0] ID_pc_plus4,
    output logic        ID_valid
);

    import if_id_fetch_stage_pkg::*;

    fetch_state_e state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pc4_q, skid_pc4_d;

    logic         pc_load;
    logic         pc_inc;
    logic [31:0]  pc_plus4;
    logic         redirect;
    logic         unused_tgt_lsb;

    // Stall beats redirect: ID keeps the branch asserted until it is accepted.
    assign redirect       = ID_branch_taken && !ID_stall;
    assign pc_plus4       = IF_pc + PC_INC;
    assign unused_tgt_lsb = ^ID_branch_target[1:0];

    if_id_fetch_stage_pc_register #(
        .RESET_PC(RESET_PC)
    ) u_pc_register (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .load_target({ID_branch_target[31:2], 2'b00}),
        .inc        (pc_inc),
        .pc         (IF_pc)
    );

    always_comb begin
        state_d      = state_q;
        if_id_d      = if_id_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;

        if (redirect) begin
            // Flush: wrong-path word in flight and any skid word are dropped.
            pc_load      = 1'b1;
            if_id_d      = '{NOP_INSTR, 32'd0, 1'b0};
            state_d      = FETCH;
            skid_instr_d = '0;
            skid_pc4_d   = '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (IF_imem_ready) begin
                        pc_inc = 1'b1;
                        if (ID_stall) begin
                            skid_instr_d = IF_imem_data;
                            skid_pc4_d   = pc_plus4;
                            state_d      = HELD;
                        end else begin
                            if_id_d = '{IF_imem_data, pc_plus4, 1'b1};
                        end
                    end else if (!ID_stall) begin
                        // Bubble keeps the previous pc_plus4.
                        if_id_d.instr = NOP_INSTR;
                        if_id_d.valid = 1'b0;
                    end
                end
                HELD: begin
                    if (!ID_stall) begin
                        if_id_d = '{skid_instr_q, skid_pc4_q, 1'b1};
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            if_id_q      <= '{NOP_INSTR, 32'd0, 1'b0};
            skid_instr_q <= '0;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            if_id_q      <= if_id_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign IF_imem_req = (state_q == FETCH) && !reset;
    assign ID_instr    = if_id_q.instr;
    assign ID_pc_plus4 = if_id_q.pc_plus4;
    assign ID_valid    = if_id_q.valid;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Self-checking bench for if_id_fetch_stage: directed scenarios with literal
// expectations, then randomized traffic, all checked every cycle against a
// behavioural model of the fetch stage.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'hE1A0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IF_imem_req;
    logic [31:0] IF_pc;
    logic        IF_imem_ready = 1'b0;
    logic [31:0] IF_imem_data;
    logic        ID_stall = 1'b0;
    logic        ID_branch_taken = 1'b0;
    logic [31:0] ID_branch_target = '0;
    logic [31:0] ID_instr;
    logic [31:0] ID_pc_plus4;
    logic        ID_valid;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    if_id_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IF_imem_req     (IF_imem_req),
        .IF_pc           (IF_pc),
        .IF_imem_ready   (IF_imem_ready),
        .IF_imem_data    (IF_imem_data),
        .ID_stall        (ID_stall),
        .ID_branch_taken (ID_branch_taken),
        .ID_branch_target(ID_branch_target),
        .ID_instr        (ID_instr),
        .ID_pc_plus4     (ID_pc_plus4),
        .ID_valid        (ID_valid)
    );

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'hE3A0_1005;
        if (a == 32'h4) return 32'hE281_1001;
        return {a[15:0] ^ 16'hC3C3, ~a[17:2]};
    endfunction

    assign IF_imem_data = IF_imem_ready ? mem_word(IF_pc) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural view of what ID should see.
    bit          m_known = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [63:0] m_skid[$];   // {instr, pc_plus4} waiting for ID

    task automatic model_step(input logic r, input logic rdy, input logic st,
                              input logic br, input logic [31:0] tgt);
        if (r) begin
            m_known = 1;
            m_pc    = 32'h0;
            m_instr = NOP;
            m_pc4   = 32'h0;
            m_valid = 0;
            m_skid.delete();
        end else if (!m_known) begin
            // nothing known before the first reset
        end else if (br && !st) begin
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_instr = NOP;
            m_pc4   = 32'h0;
            m_valid = 0;
            m_skid.delete();
        end else if (m_skid.size() != 0) begin
            if (!st) begin
                {m_instr, m_pc4} = m_skid.pop_front();
                m_valid = 1;
            end
        end else if (rdy) begin
            if (st) m_skid.push_back({mem_word(m_pc), m_pc + 32'd4});
            else begin
                m_instr = mem_word(m_pc);
                m_pc4   = m_pc + 32'd4;
                m_valid = 1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!st) begin
            m_instr = NOP;
            m_valid = 0;
        end
    endtask

    // Compare process: every cycle, mid-period.
    always @(negedge clk) begin
        if (m_known) begin
            chk("IF_pc", IF_pc, m_pc);
            chk("ID_instr", ID_instr, m_instr);
            chk("ID_pc_plus4", ID_pc_plus4, m_pc4);
            chk("ID_valid", {31'd0, ID_valid}, {31'd0, m_valid});
            chk("IF_imem_req", {31'd0, IF_imem_req},
                {31'd0, (!reset && m_skid.size() == 0)});
        end
    end

    // Apply one cycle of inputs, clock, then advance the model.
    task automatic cyc(input logic r, input logic rdy, input logic st,
                       input logic br, input logic [31:0] tgt);
        reset            = r;
        IF_imem_ready    = rdy;
        ID_stall         = st;
        ID_branch_taken  = br;
        ID_branch_target = tgt;
        @(posedge clk);
        #1;
        model_step(r, rdy, st, br, tgt);
    endtask

    initial begin
        // Reset
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("rst_pc", IF_pc, 32'h0);
        chk("rst_instr", ID_instr, NOP);
        chk("rst_valid", {31'd0, ID_valid}, 32'd0);

        // Back-to-back fetches
        cyc(0, 1, 0, 0, 0);
        chk("f1_instr", ID_instr, 32'hE3A0_1005);
        chk("f1_pc4", ID_pc_plus4, 32'h4);
        chk("f1_valid", {31'd0, ID_valid}, 32'd1);
        cyc(0, 1, 0, 0, 0);
        chk("f2_instr", ID_instr, 32'hE281_1001);
        chk("f2_pc4", ID_pc_plus4, 32'h8);
        chk("f2_pc", IF_pc, 32'h8);

        // Stall with ready: word at 8 goes to skid
        repeat (3) cyc(0, 1, 1, 0, 0);
        chk("stall_pc", IF_pc, 32'hC);
        chk("stall_pc4", ID_pc_plus4, 32'h8);
        chk("stall_req", {31'd0, IF_imem_req}, 32'd0);
        cyc(0, 1, 0, 0, 0);
        chk("skid_instr", ID_instr, mem_word(32'h8));
        chk("skid_pc4", ID_pc_plus4, 32'hC);
        cyc(0, 1, 0, 0, 0);
        chk("resume_pc4", ID_pc_plus4, 32'h10);

        // Bubbles
        repeat (2) begin
            cyc(0, 0, 0, 0, 0);
            chk("bub_instr", ID_instr, NOP);
            chk("bub_pc4", ID_pc_plus4, 32'h10);
            chk("bub_pc", IF_pc, 32'h10);
        end
        cyc(0, 1, 0, 0, 0);
        chk("after_bub", ID_pc_plus4, 32'h14);

        // Redirect drops the same-cycle word
        cyc(0, 1, 0, 1, 32'h0000_0103);
        chk("br_pc", IF_pc, 32'h100);
        chk("br_instr", ID_instr, NOP);
        chk("br_valid", {31'd0, ID_valid}, 32'd0);

        // Branch under stall ignored, then taken from HELD (skid dropped)
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 32'h200);
        chk("brst_pc", IF_pc, 32'h108);
        chk("brst_pc4", ID_pc_plus4, 32'h104);
        cyc(0, 0, 0, 1, 32'h200);
        chk("brheld_pc", IF_pc, 32'h200);
        cyc(0, 1, 0, 0, 0);
        chk("brheld_pc4", ID_pc_plus4, 32'h204);

        // PC wrap
        cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 0, 0);
        chk("wrap_pc4", ID_pc_plus4, 32'h0);
        chk("wrap_pc", IF_pc, 32'h0);
        cyc(0, 1, 0, 0, 0);
        chk("wrap_instr", ID_instr, 32'hE3A0_1005);

        // Reset while HELD
        cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("rh_pc", IF_pc, 32'h0);
        chk("rh_instr", ID_instr, NOP);
        chk("rh_pc4", ID_pc_plus4, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
            cyc($urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 70,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 10,
                tgt);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
